sensor_snapshot_bank: RTL and testbench

//   Sits between the encoder/odometer/sonar counters and the SPI slave's DataAddr/DataToRPi read port.
//   On each SPI transaction start (CS falling edge) it atomically latches all five live counts,
//   so the RPi reads one coherent set per transaction.

---
 rtl/sensor_snapshot_bank_if.sv | 26 ++
 rtl/sensor_snapshot_bank.sv | 194 +++++++++++++++++++
 tb/tb_sensor_snapshot_bank.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_snapshot_bank_if.sv
// sensor_snapshot_bank_if
//   Read port between the snapshot bank and the SPI slave.
//   data_addr   register address chosen by the SPI slave
//   data_out    registered read data returned to the SPI slave
//   snap_valid  high once a coherent snapshot exists since reset
//   master: SPI slave side (drives data_addr)
//   slave : snapshot bank side (drives data_out, snap_valid)
interface sensor_snapshot_bank_if #(
  parameter int WIDTH = 32
);
  logic [7:0]       data_addr;
  logic [WIDTH-1:0] data_out;
  logic             snap_valid;

  modport master (
    output data_addr,
    input  data_out,
    input  snap_valid
  );

  modport slave (
    input  data_addr,
    output data_out,
    output snap_valid
  );
endinterface

// File: rtl/sensor_snapshot_bank.sv
// sensor_snapshot_bank
//   Latches all five live sensor counts atomically on each SPI chip-select
//   falling edge so the RPi reads one coherent set per transaction. Also keeps
//   per-channel deltas, the capture timestamp and the time between captures
//   for velocity estimation. A holdoff window after each capture rejects
//   further chip-select edges and counts them as ignored.
//
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   spi_cs         raw chip-select from the RPi, active low, asynchronous
//   cnt_left_enc   live left motor encoder count
//   cnt_right_enc  live right motor encoder count
//   cnt_left_odo   live left odometer count
//   cnt_right_odo  live right odometer count
//   cnt_sonar      live sonar echo count
//   rd             read port (data_addr in, data_out / snap_valid out)
//
//   state | meaning
//   EMPTY | no snapshot taken since reset
//   HOLD  | snapshot taken, holdoff window running, CS edges ignored
//   VALID | snapshot available, next CS falling edge captures
module sensor_snapshot_bank #(
  parameter int WIDTH   = 32,
  parameter int HOLDOFF = 50
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  spi_cs,
  input  logic [WIDTH-1:0]      cnt_left_enc,
  input  logic [WIDTH-1:0]      cnt_right_enc,
  input  logic [WIDTH-1:0]      cnt_left_odo,
  input  logic [WIDTH-1:0]      cnt_right_odo,
  input  logic [WIDTH-1:0]      cnt_sonar,
  sensor_snapshot_bank_if.slave rd
);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = (HOLDOFF > 0) ? HW'(HOLDOFF - 1) : '0;
  localparam logic HOLD_EN = (HOLDOFF > 0);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [HW-1:0]    hold_cnt;
  logic             cs_s1, cs_s2, cs_s3;
  logic             fall;
  logic             capture;
  logic             ign_evt;
  logic             in_hold;
  logic             snap_valid_i;

  logic [WIDTH-1:0] ts;
  logic [WIDTH-1:0] snap_le, snap_re, snap_lo, snap_ro, snap_so;
  logic [WIDTH-1:0] delta_le, delta_re, delta_lo, delta_ro;
  logic [WIDTH-1:0] snap_ts, dt, seq;
  logic [7:0]       ign_cnt;
  logic [WIDTH-1:0] rd_mux;

  // cs_s1/cs_s2 resolve metastability; cs_s3 is only an edge-detect delay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_s1 <= 1'b1;
      cs_s2 <= 1'b1;
      cs_s3 <= 1'b1;
    end else begin
      cs_s1 <= spi_cs;
      cs_s2 <= cs_s1;
      cs_s3 <= cs_s2;
    end
  end

  assign fall = cs_s3 & ~cs_s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_EMPTY;
      hold_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        hold_cnt <= HOLD_LOAD;
      end else if (state_q == ST_HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    ign_evt = 1'b0;
    case (state_q)
      ST_EMPTY, ST_VALID: begin
        if (fall) begin
          capture = 1'b1;
          state_d = HOLD_EN ? ST_HOLD : ST_VALID;
        end
      end
      ST_HOLD: begin
        ign_evt = fall;
        // Terminal count reached: the window has lasted HOLDOFF cycles.
        if (hold_cnt == '0) begin
          state_d = ST_VALID;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign in_hold      = (state_q == ST_HOLD);
  assign snap_valid_i = (state_q != ST_EMPTY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts <= '0;
    end else begin
      ts <= ts + 1'b1;
    end
  end

  // Deltas use the previous snapshot before it is overwritten in the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_le  <= '0;
      snap_re  <= '0;
      snap_lo  <= '0;
      snap_ro  <= '0;
      snap_so  <= '0;
      delta_le <= '0;
      delta_re <= '0;
      delta_lo <= '0;
      delta_ro <= '0;
      snap_ts  <= '0;
      dt       <= '0;
      seq      <= '0;
    end else if (capture) begin
      snap_le  <= cnt_left_enc;
      snap_re  <= cnt_right_enc;
      snap_lo  <= cnt_left_odo;
      snap_ro  <= cnt_right_odo;
      snap_so  <= cnt_sonar;
      delta_le <= cnt_left_enc  - snap_le;
      delta_re <= cnt_right_enc - snap_re;
      delta_lo <= cnt_left_odo  - snap_lo;
      delta_ro <= cnt_right_odo - snap_ro;
      snap_ts  <= ts;
      dt       <= ts - snap_ts;
      seq      <= seq + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ign_cnt <= '0;
    end else if (ign_evt && ign_cnt != 8'hFF) begin
      ign_cnt <= ign_cnt + 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd.data_addr)
      8'h00: rd_mux = snap_le;
      8'h01: rd_mux = snap_re;
      8'h02: rd_mux = snap_lo;
      8'h03: rd_mux = snap_ro;
      8'h04: rd_mux = snap_so;
      8'h05: rd_mux = delta_le;
      8'h06: rd_mux = delta_re;
      8'h07: rd_mux = delta_lo;
      8'h08: rd_mux = delta_ro;
      8'h09: rd_mux = snap_ts;
      8'h0A: rd_mux = dt;
      8'h0B: rd_mux = seq;
      8'h0C: rd_mux = WIDTH'({ign_cnt, 6'b0, in_hold, snap_valid_i});
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd.data_out <= '0;
    end else begin
      rd.data_out <= rd_mux;
    end
  end

  assign rd.snap_valid = snap_valid_i;

endmodule

// File: tb/tb_sensor_snapshot_bank.sv
module tb_sensor_snapshot_bank;
  localparam int W = 32;
  localparam int H = 50;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         spi_cs = 1'b1;
  logic [W-1:0] c_le = '0, c_re = '0, c_lo = '0, c_ro = '0, c_so = '0;
  bit           churn = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int cap_cyc = 0;

  sensor_snapshot_bank_if #(.WIDTH(W)) bus ();

  sensor_snapshot_bank #(.WIDTH(W), .HOLDOFF(H)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .spi_cs        (spi_cs),
    .cnt_left_enc  (c_le),
    .cnt_right_enc (c_re),
    .cnt_left_odo  (c_lo),
    .cnt_right_odo (c_ro),
    .cnt_sonar     (c_so),
    .rd            (bus)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference model: a capture happens at edge n when CS was sampled high at
  // edge n-3 and low at edge n-2, unless edge n falls within the H edges
  // following the previous accepted capture (then it is counted as ignored).
  logic [W-1:0] m_snap [5];
  logic [W-1:0] m_delta [4];
  logic [W-1:0] m_sts, m_dt, m_seq;
  int           m_ign, m_e, m_lastc;
  bit           m_have;
  bit           cs_n1, cs_n2, cs_n3;

  always @(posedge clk or negedge reset_n) begin : model
    int n;
    logic [W-1:0] cur [5];
    if (!reset_n) begin
      for (int i = 0; i < 5; i++) m_snap[i] = '0;
      for (int i = 0; i < 4; i++) m_delta[i] = '0;
      m_sts = '0; m_dt = '0; m_seq = '0;
      m_ign = 0; m_e = 0; m_lastc = 0; m_have = 0;
      cs_n1 = 1; cs_n2 = 1; cs_n3 = 1;
    end else begin
      n = m_e + 1;
      cur[0] = c_le; cur[1] = c_re; cur[2] = c_lo; cur[3] = c_ro; cur[4] = c_so;
      if (cs_n3 && !cs_n2) begin
        if (!m_have || n > m_lastc + H) begin
          for (int i = 0; i < 4; i++) m_delta[i] = cur[i] - m_snap[i];
          for (int i = 0; i < 5; i++) m_snap[i] = cur[i];
          m_dt = W'(m_e) - m_sts;
          m_sts = W'(m_e);
          m_seq = m_seq + 1;
          m_have = 1;
          m_lastc = n;
        end else if (m_ign < 255) begin
          m_ign++;
        end
      end
      cs_n3 = cs_n2; cs_n2 = cs_n1; cs_n1 = spi_cs;
      m_e = n;
    end
  end

  // Expected register value as loaded into data_out at the most recent edge.
  function automatic logic [W-1:0] exp_reg(input logic [7:0] a);
    bit ih;
    logic [7:0] ig;
    ih = m_have && (m_e > m_lastc) && (m_e <= m_lastc + H);
    ig = 8'(m_ign);
    if (a <= 8'h04)       return m_snap[a[2:0]];
    else if (a <= 8'h08)  return m_delta[int'(a) - 5];
    else if (a == 8'h09)  return m_sts;
    else if (a == 8'h0A)  return m_dt;
    else if (a == 8'h0B)  return m_seq;
    else if (a == 8'h0C)  return W'({ig, 6'b0, ih, m_have});
    return '0;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic randomize_counts();
    c_le = $urandom; c_re = $urandom; c_lo = $urandom; c_ro = $urandom; c_so = $urandom;
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [W-1:0] v);
    @(negedge clk);
    bus.data_addr = a;
    if (churn) randomize_counts();
    @(posedge clk);
    #1;
    v = bus.data_out;
  endtask

  task automatic do_capture();
    @(negedge clk) spi_cs = 1'b1;
    wait_cycles(60);
    @(negedge clk) spi_cs = 1'b0;
    wait_cycles(8);
  endtask

  task automatic test_reset();
    logic [W-1:0] v;
    reset_n = 1'b0;
    spi_cs = 1'b1;
    wait_cycles(3);
    @(negedge clk) reset_n = 1'b1;
    wait_cycles(2);
    for (int a = 0; a < 16; a++) begin
      read_reg(8'(a), v);
      vectors++;
      if (v !== '0) begin
        miscompares++;
        $display("FAIL reset_read[%0h]: got %h expected 0", a, v);
      end
    end
    vectors++;
    if (bus.snap_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_snap_valid: got %b expected 0", bus.snap_valid);
    end
  endtask

  task automatic test_first_capture();
    logic [W-1:0] v;
    logic [W-1:0] want [13];
    c_le = 100; c_re = 200; c_lo = 32'hFFFF_FFFB; c_ro = 7; c_so = 1234;
    wait_cycles(4);
    @(negedge clk) spi_cs = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (bus.snap_valid !== (e == 3)) begin
        miscompares++;
        $display("FAIL capture_edge%0d: snap_valid got %b expected %b", e, bus.snap_valid, (e == 3));
      end
    end
    cap_cyc = cyc;
    wait_cycles(4);
    want[0] = 100; want[1] = 200; want[2] = 32'hFFFF_FFFB; want[3] = 7; want[4] = 1234;
    want[5] = 100; want[6] = 200; want[7] = 32'hFFFF_FFFB; want[8] = 7;
    for (int a = 0; a < 13; a++) begin
      read_reg(8'(a), v);
      vectors++;
      if (a == 9 || a == 10) begin
        if (v !== exp_reg(8'(a))) begin
          miscompares++;
          $display("FAIL first_ts[%0h]: got %h expected %h", a, v, exp_reg(8'(a)));
        end
      end else if (a == 11) begin
        if (v !== 32'd1) begin
          miscompares++;
          $display("FAIL first_seq: got %h expected 1", v);
        end
      end else if (a == 12) begin
        if (v[0] !== 1'b1) begin
          miscompares++;
          $display("FAIL first_status_bit0: got %b expected 1", v[0]);
        end
      end else if (v !== want[a]) begin
        miscompares++;
        $display("FAIL first_read[%0h]: got %h expected %h", a, v, want[a]);
      end
    end
  endtask

  task automatic test_delta_dt();
    logic [W-1:0] v;
    @(negedge clk) spi_cs = 1'b1;
    c_le = 150;
    while (cyc < cap_cyc + 997) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk) spi_cs = 1'b0;
    wait_cycles(8);
    read_reg(8'h05, v);
    vectors++;
    if (v !== 32'd50) begin
      miscompares++;
      $display("FAIL delta_left_enc: got %0d expected 50", v);
    end
    read_reg(8'h0A, v);
    vectors++;
    if (v !== 32'd1000) begin
      miscompares++;
      $display("FAIL dt_1000: got %0d expected 1000", v);
    end
    read_reg(8'h0B, v);
    vectors++;
    if (v !== 32'd2) begin
      miscompares++;
      $display("FAIL seq_2: got %0d expected 2", v);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] v;
    c_le = 32'hFFFF_FFF0;
    do_capture();
    c_le = 32'h0000_0010;
    do_capture();
    read_reg(8'h05, v);
    vectors++;
    if (v !== 32'h0000_0020) begin
      miscompares++;
      $display("FAIL wrap_up: got %h expected 00000020", v);
    end
    c_le = 32'h0000_000D;
    do_capture();
    read_reg(8'h05, v);
    vectors++;
    if (v !== 32'hFFFF_FFFD) begin
      miscompares++;
      $display("FAIL wrap_down: got %h expected fffffffd", v);
    end
  endtask

  task automatic pulse_cs();
    @(negedge clk) spi_cs = 1'b1;
    @(negedge clk);
    @(negedge clk) spi_cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_holdoff();
    logic [W-1:0] v;
    logic [W-1:0] seq_before;
    do_capture();
    seq_before = m_seq;
    for (int i = 0; i < 3; i++) pulse_cs();
    wait_cycles(60);
    read_reg(8'h0B, v);
    vectors++;
    if (v !== seq_before) begin
      miscompares++;
      $display("FAIL hold_seq: got %0d expected %0d", v, seq_before);
    end
    read_reg(8'h0C, v);
    vectors++;
    if (v[15:8] !== 8'd3) begin
      miscompares++;
      $display("FAIL hold_ign3: got %0d expected 3", v[15:8]);
    end
    for (int i = 0; i < 300; i++) pulse_cs();
    wait_cycles(60);
    read_reg(8'h0C, v);
    vectors++;
    if (v[15:8] !== 8'd255) begin
      miscompares++;
      $display("FAIL hold_ign_sat: got %0d expected 255", v[15:8]);
    end
    read_reg(8'h0B, v);
    vectors++;
    if (v !== exp_reg(8'h0B)) begin
      miscompares++;
      $display("FAIL hold_seq_model: got %0d expected %0d", v, exp_reg(8'h0B));
    end
  endtask

  task automatic test_random();
    logic [W-1:0] v;
    logic [7:0]   a;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        randomize_counts();
        if ($urandom_range(0, 7) == 0) spi_cs = ~spi_cs;
      end
      churn = 1'b1;
      repeat (60) begin
        @(negedge clk);
        randomize_counts();
      end
      for (int k = 0; k < 18; k++) begin
        a = (k < 16) ? 8'(k) : 8'($urandom_range(16, 255));
        read_reg(a, v);
        vectors++;
        if (v !== exp_reg(a)) begin
          miscompares++;
          $display("FAIL random_r%0d[%0h]: got %h expected %h", r, a, v, exp_reg(a));
        end
      end
      churn = 1'b0;
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [W-1:0] v;
    do_capture();
    wait_cycles(5);
    @(negedge clk) reset_n = 1'b0;
    for (int a = 0; a < 13; a++) begin
      read_reg(8'(a), v);
      vectors++;
      if (v !== '0) begin
        miscompares++;
        $display("FAIL midreset_read[%0h]: got %h expected 0", a, v);
      end
    end
    vectors++;
    if (bus.snap_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_snap_valid: got %b expected 0", bus.snap_valid);
    end
    @(negedge clk) reset_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (bus.snap_valid !== (e == 3)) begin
        miscompares++;
        $display("FAIL release_edge%0d: snap_valid got %b expected %b", e, bus.snap_valid, (e == 3));
      end
    end
    wait_cycles(6);
    read_reg(8'h0B, v);
    vectors++;
    if (v !== 32'd1) begin
      miscompares++;
      $display("FAIL release_seq: got %0d expected 1", v);
    end
    for (int a = 0; a < 13; a++) begin
      read_reg(8'(a), v);
      vectors++;
      if (v !== exp_reg(8'(a))) begin
        miscompares++;
        $display("FAIL release_read[%0h]: got %h expected %h", a, v, exp_reg(8'(a)));
      end
    end
  endtask

  initial begin
    bus.data_addr = 8'h00;
    test_reset();
    test_first_capture();
    test_delta_dt();
    test_wrap();
    test_holdoff();
    test_random();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
